// File: rtl/morse_pkg.sv
// Shared types, symbol constants and the digit decode table for the Morse key decoder.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRESS  = 2'd1,
      GAP    = 2'd2,
      DECODE = 2'd3
   } state_t;

   localparam logic DOT  = 1'b0;
   localparam logic DASH = 1'b1;

   localparam int unsigned SYMS_PER_DIGIT = 5;
   localparam int unsigned SYM_CNT_W      = 3;
   localparam int unsigned DIGIT_W        = 4;

   // Maps a 5-symbol pattern (first symbol in the MSB) to {valid, digit}.
   function automatic logic [DIGIT_W:0] decode_digit(input logic [SYMS_PER_DIGIT-1:0] pat);
      logic [DIGIT_W:0] res;
      case (pat)
         5'b01111: res = {1'b1, 4'd1};
         5'b00111: res = {1'b1, 4'd2};
         5'b00011: res = {1'b1, 4'd3};
         5'b00001: res = {1'b1, 4'd4};
         5'b00000: res = {1'b1, 4'd5};
         5'b10000: res = {1'b1, 4'd6};
         5'b11000: res = {1'b1, 4'd7};
         5'b11100: res = {1'b1, 4'd8};
         5'b11110: res = {1'b1, 4'd9};
         5'b11111: res = {1'b1, 4'd0};
         default:  res = {1'b0, 4'd0};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/morse_key_decoder_key_sync_edge.sv
// Two-flop synchroniser for the raw key plus single-cycle rise/fall flags.
module key_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic rise_c,
   output logic fall_c
);

   logic key_meta;
   logic key_s;
   logic key_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_meta <= 1'b0;
         key_s    <= 1'b0;
         key_d    <= 1'b0;
      end else begin
         key_meta <= key_in;
         key_s    <= key_meta;
         key_d    <= key_s;
      end
   end

   // Edge flags are combinational so the FSM reacts in the same cycle key_s changes.
   assign rise_c = key_s & ~key_d;
   assign fall_c = ~key_s & key_d;

endmodule

// File: rtl/morse_key_decoder.sv
// Times Morse key presses into dots/dashes, collects five symbols and decodes a digit.
// Optional gap timeout is enabled by defining MORSE_GAP_TIMEOUT_EN.
module morse_key_decoder
   import morse_pkg::*;
#(
   parameter int unsigned MIN_CYCLES  = 500_000,
   parameter int unsigned DASH_CYCLES = 25_000_000,
   parameter int unsigned GAP_CYCLES  = 150_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      key_in,
   output logic [DIGIT_W-1:0]        user_input,
   output logic                      load,
   output logic                      invalid,
   output logic [SYM_CNT_W-1:0]      sym_count,
   output logic [SYMS_PER_DIGIT-1:0] sym_bits
);

   localparam int unsigned PRESS_W = $clog2(DASH_CYCLES) + 1;

   if (MIN_CYCLES == 0 || MIN_CYCLES >= DASH_CYCLES || GAP_CYCLES == 0) begin : g_param_check
      $error("morse_key_decoder: need 0 < MIN_CYCLES < DASH_CYCLES and GAP_CYCLES > 0");
   end

   logic rise_c;
   logic fall_c;

   key_sync_edge u_key_sync_edge (
      .clk    (clk),
      .rst    (rst),
      .key_in (key_in),
      .rise_c (rise_c),
      .fall_c (fall_c)
   );

   state_t                    state, state_nxt;
   logic [PRESS_W-1:0]        press_cnt, press_cnt_nxt;
   logic [SYMS_PER_DIGIT-1:0] sym_bits_nxt;
   logic [SYM_CNT_W-1:0]      sym_count_nxt;
   logic [SYM_CNT_W-1:0]      sym_count_inc;
   logic [DIGIT_W-1:0]        user_input_nxt;
   logic                      load_nxt;
   logic                      invalid_nxt;
   logic [DIGIT_W:0]          dec;

`ifdef MORSE_GAP_TIMEOUT_EN
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;
   logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) gap_cnt <= '0;
      else     gap_cnt <= gap_cnt_nxt;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         press_cnt  <= '0;
         sym_bits   <= '0;
         sym_count  <= '0;
         user_input <= '0;
         load       <= 1'b0;
         invalid    <= 1'b0;
      end else begin
         state      <= state_nxt;
         press_cnt  <= press_cnt_nxt;
         sym_bits   <= sym_bits_nxt;
         sym_count  <= sym_count_nxt;
         user_input <= user_input_nxt;
         load       <= load_nxt;
         invalid    <= invalid_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      press_cnt_nxt  = press_cnt;
      sym_bits_nxt   = sym_bits;
      sym_count_nxt  = sym_count;
      user_input_nxt = user_input;
      load_nxt       = 1'b0;
      invalid_nxt    = 1'b0;
      sym_count_inc  = sym_count + SYM_CNT_W'(1);
      dec            = decode_digit(sym_bits);
`ifdef MORSE_GAP_TIMEOUT_EN
      gap_cnt_nxt    = gap_cnt;
`endif

      if (!enable) begin
         // Controller revoked decoding: abandon any partial entry silently.
         state_nxt     = IDLE;
         press_cnt_nxt = '0;
         sym_bits_nxt  = '0;
         sym_count_nxt = '0;
`ifdef MORSE_GAP_TIMEOUT_EN
         gap_cnt_nxt   = '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               sym_bits_nxt  = '0;
               sym_count_nxt = '0;
               if (rise_c) begin
                  state_nxt     = PRESS;
                  press_cnt_nxt = PRESS_W'(1);
               end
            end

            PRESS: begin
               if (press_cnt < PRESS_W'(DASH_CYCLES)) press_cnt_nxt = press_cnt + PRESS_W'(1);
`ifdef MORSE_GAP_TIMEOUT_EN
               gap_cnt_nxt = '0;
`endif
               if (fall_c) begin
                  if (press_cnt < PRESS_W'(MIN_CYCLES)) begin
                     state_nxt = (sym_count == '0) ? IDLE : GAP;
                  end else begin
                     sym_bits_nxt  = {sym_bits[SYMS_PER_DIGIT-2:0],
                                      (press_cnt >= PRESS_W'(DASH_CYCLES)) ? DASH : DOT};
                     sym_count_nxt = sym_count_inc;
                     state_nxt     = (sym_count_inc == SYM_CNT_W'(SYMS_PER_DIGIT)) ? DECODE : GAP;
                  end
               end
            end

            GAP: begin
               if (rise_c) begin
                  state_nxt     = PRESS;
                  press_cnt_nxt = PRESS_W'(1);
`ifdef MORSE_GAP_TIMEOUT_EN
                  gap_cnt_nxt   = '0;
               end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  state_nxt     = IDLE;
                  invalid_nxt   = 1'b1;
                  sym_bits_nxt  = '0;
                  sym_count_nxt = '0;
                  gap_cnt_nxt   = '0;
               end else begin
                  gap_cnt_nxt   = gap_cnt + GAP_W'(1);
`endif
               end
            end

            DECODE: begin
               state_nxt     = IDLE;
               sym_bits_nxt  = '0;
               sym_count_nxt = '0;
               if (dec[DIGIT_W]) begin
                  user_input_nxt = dec[DIGIT_W-1:0];
                  load_nxt       = 1'b1;
               end else begin
                  invalid_nxt    = 1'b1;
               end
            end

            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Self-checking bench for morse_key_decoder: directed scenarios plus random digits
// compared against a rule-based digit model.
module tb_morse_key_decoder;

   localparam int unsigned MIN  = 2;
   localparam int unsigned DASH = 8;
   localparam int unsigned GAPC = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       key_in;
   logic [3:0] user_input;
   logic       load;
   logic       invalid;
   logic [2:0] sym_count;
   logic [4:0] sym_bits;

   int n_cmp = 0;
   int n_mis = 0;
   int load_cnt = 0;
   int inv_cnt = 0;
   int both_cnt = 0;
   int drift_cnt = 0;
   logic [4:0] last_full = '0;
   logic [3:0] prev_ui = '0;
   int exp_ui = 0;

   always #5 clk = ~clk;

   morse_key_decoder #(
      .MIN_CYCLES  (MIN),
      .DASH_CYCLES (DASH),
      .GAP_CYCLES  (GAPC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .key_in     (key_in),
      .user_input (user_input),
      .load       (load),
      .invalid    (invalid),
      .sym_count  (sym_count),
      .sym_bits   (sym_bits)
   );

   // Strobe and output observation on the inactive edge.
   always @(negedge clk) begin
      if (load)            load_cnt  <= load_cnt + 1;
      if (invalid)         inv_cnt   <= inv_cnt + 1;
      if (load && invalid) both_cnt  <= both_cnt + 1;
      if (!rst && user_input !== prev_ui && !load) drift_cnt <= drift_cnt + 1;
      if (sym_count == 3'd5) last_full <= sym_bits;
      prev_ui <= user_input;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic press(input int dur, input int gap);
      @(posedge clk);
      #1 key_in = 1'b1;
      repeat (dur) @(posedge clk);
      #1 key_in = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   // Digits 1-5: n dots then dashes (5 = all dots); 6-9: n-5 dashes then dots; 0 = all dashes.
   function automatic int model_digit(input bit s[5]);
      int k = 1;
      while (k < 5 && s[k] == s[0]) k++;
      for (int j = k; j < 5; j++) if (s[j] == s[0]) return -1;
      if (k == 5) return s[0] ? 0 : 5;
      return s[0] ? k + 5 : k;
   endfunction

   task automatic enter_digit(input string tag, input int durs[5], input bit glitchy);
      int l0 = load_cnt;
      int i0 = inv_cnt;
      int m;
      bit s[5];
      logic [4:0] pat = '0;
      for (int i = 0; i < 5; i++) begin
         if (glitchy && ($urandom % 4) == 0) press(1, 2);
         s[i] = (durs[i] >= int'(DASH));
         pat  = {pat[3:0], s[i]};
         press(durs[i], (i == 4) ? 8 : 1 + int'($urandom % 4));
      end
      m = model_digit(s);
      check({tag, "_bits"}, last_full, pat);
      if (m >= 0) begin
         exp_ui = m;
         check({tag, "_load"}, load_cnt - l0, 1);
         check({tag, "_inv"},  inv_cnt - i0, 0);
      end else begin
         check({tag, "_load"}, load_cnt - l0, 0);
         check({tag, "_inv"},  inv_cnt - i0, 1);
      end
      check({tag, "_digit"}, user_input, exp_ui);
      check({tag, "_count"}, sym_count, 0);
   endtask

   initial begin
      int l0, i0;
      int d[5];

      rst = 1'b1; enable = 1'b0; key_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ui",    user_input, 0);
      check("rst_load",  load, 0);
      check("rst_inv",   invalid, 0);
      check("rst_count", sym_count, 0);
      check("rst_bits",  sym_bits, 0);
      rst = 1'b0; enable = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      enter_digit("d1", '{3, 10, 10, 10, 10}, 1'b0);
      enter_digit("d5", '{3, 3, 3, 3, 3}, 1'b0);
      enter_digit("d0", '{10, 10, 10, 10, 10}, 1'b0);
      enter_digit("bad10100", '{10, 3, 10, 3, 3}, 1'b0);

      // Glitch between two dots must not count as a symbol.
      press(3, 4);
      check("gl_cnt1", sym_count, 1);
      press(1, 4);
      check("gl_cnt_glitch", sym_count, 1);
      press(3, 4);
      check("gl_cnt2", sym_count, 2);
      l0 = load_cnt;
      press(3, 1); press(3, 1); press(3, 8);
      exp_ui = 5;
      check("gl_load", load_cnt - l0, 1);
      check("gl_digit", user_input, 5);

      // Dropping enable mid-entry abandons it without strobes.
      l0 = load_cnt; i0 = inv_cnt;
      press(10, 2); press(10, 2); press(3, 4);
      check("en_cnt3", sym_count, 3);
      enable = 1'b0;
      @(posedge clk);
      #1 enable = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("en_cnt0", sym_count, 0);
      check("en_bits0", sym_bits, 0);
      check("en_load", load_cnt - l0, 0);
      check("en_inv", inv_cnt - i0, 0);
      enter_digit("d7", '{10, 10, 3, 3, 3}, 1'b0);

      // Key already held when enable rises produces nothing.
      enable = 1'b0; key_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 enable = 1'b1;
      repeat (12) @(posedge clk);
      #1 key_in = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("held_cnt", sym_count, 0);

      // Long gap after two symbols.
      l0 = load_cnt; i0 = inv_cnt;
      press(3, 2); press(10, 4);
      repeat (30) @(posedge clk);
      #1;
`ifdef MORSE_GAP_TIMEOUT_EN
      check("gap_inv", inv_cnt - i0, 1);
      check("gap_cnt", sym_count, 0);
`else
      check("gap_inv", inv_cnt - i0, 0);
      check("gap_cnt", sym_count, 2);
      enable = 1'b0;
      @(posedge clk);
      #1 enable = 1'b1;
      @(posedge clk);
      #1;
`endif
      check("gap_load", load_cnt - l0, 0);

      // Random digits, mostly valid, with occasional glitches.
      for (int n = 0; n < 12; n++) begin
         int v = ($urandom % 4 == 0) ? -1 : int'($urandom % 10);
         for (int i = 0; i < 5; i++) begin
            bit dash;
            if (v < 0)       dash = bit'($urandom % 2);
            else if (v == 0) dash = 1'b1;
            else if (v <= 5) dash = (i >= v);
            else             dash = (i < v - 5);
            d[i] = dash ? int'($urandom_range(8, 12)) : int'($urandom_range(2, 7));
         end
         enter_digit($sformatf("rnd%0d", n), d, 1'b1);
      end

      // Asynchronous reset in the middle of a press.
      enter_digit("d9", '{10, 10, 10, 10, 3}, 1'b0);
      press(3, 2); press(10, 2);
      @(posedge clk);
      #1 key_in = 1'b1;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ui",    user_input, 0);
      check("mid_rst_count", sym_count, 0);
      check("mid_rst_bits",  sym_bits, 0);
      check("mid_rst_load",  load, 0);
      check("mid_rst_inv",   invalid, 0);
      key_in = 1'b0;
      exp_ui = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      enter_digit("d3", '{3, 3, 3, 10, 10}, 1'b0);

      check("never_both", both_cnt, 0);
      check("ui_stable", drift_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
